joypad_conditioner: RTL and testbench

//  Converts raw board buttons/switches into the eight active-low joypad_* inputs of the GameBoy core.

---
 rtl/joypad_conditioner_if.sv | 46 ++++
 rtl/joypad_conditioner.sv | 103 ++++++++++
 tb/tb_joypad_conditioner.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/joypad_conditioner_if.sv
// Button/joypad bundle between board-level inputs and the GameBoy core.
// slave = conditioner side, master = board/core side.
interface joypad_conditioner_if;
    logic [7:0] btn_raw;
    logic       turbo_on;
    logic       joypad_a;
    logic       joypad_b;
    logic       joypad_select;
    logic       joypad_start;
    logic       joypad_right;
    logic       joypad_left;
    logic       joypad_up;
    logic       joypad_down;
    logic [7:0] btn_state;
    logic       joy_irq;

    modport slave (
        input  btn_raw,
        input  turbo_on,
        output joypad_a,
        output joypad_b,
        output joypad_select,
        output joypad_start,
        output joypad_right,
        output joypad_left,
        output joypad_up,
        output joypad_down,
        output btn_state,
        output joy_irq
    );

    modport master (
        output btn_raw,
        output turbo_on,
        input  joypad_a,
        input  joypad_b,
        input  joypad_select,
        input  joypad_start,
        input  joypad_right,
        input  joypad_left,
        input  joypad_up,
        input  joypad_down,
        input  btn_state,
        input  joy_irq
    );
endinterface

// File: rtl/joypad_conditioner.sv
// Sync + debounce of 8 raw buttons into active-low GameBoy joypad lines.
// Optional A/B autofire is built only when TURBO_EN is defined.
module joypad_conditioner #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int TURBO_PERIOD    = 70000
) (
    input  logic                 clk,
    input  logic                 rst,
    joypad_conditioner_if.slave  bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [7:0]    s1;
    logic [7:0]    s2;
    logic [7:0]    stable;
    logic [7:0]    stable_nx;
    logic [CW-1:0] cnt    [8];
    logic [CW-1:0] cnt_nx [8];
    logic          irq;
    logic [1:0]    jp_ab;

    // Any return to the stable level restarts the count from zero.
    always_comb begin
        stable_nx = stable;
        for (int i = 0; i < 8; i++) begin
            cnt_nx[i] = '0;
            if (s2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST)
                    stable_nx[i] = s2[i];
                else
                    cnt_nx[i] = cnt[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            irq    <= 1'b0;
            for (int i = 0; i < 8; i++)
                cnt[i] <= '0;
        end else begin
            s1     <= bus.btn_raw;
            s2     <= s1;
            stable <= stable_nx;
            irq    <= |(stable_nx & ~stable);
            for (int i = 0; i < 8; i++)
                cnt[i] <= cnt_nx[i];
        end
    end

`ifdef TURBO_EN
    localparam int TW = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TURBO_PERIOD - 1);

    logic [TW-1:0] tcnt [2];
    logic [1:0]    phase;
    logic [1:0]    t_act;

    assign t_act = {2{bus.turbo_on}} & stable[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            for (int i = 0; i < 2; i++)
                tcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!t_act[i]) begin
                    tcnt[i]  <= '0;
                    phase[i] <= 1'b0;
                end else if (tcnt[i] == T_LAST) begin
                    tcnt[i]  <= '0;
                    phase[i] <= ~phase[i];
                end else begin
                    tcnt[i]  <= tcnt[i] + TW'(1);
                end
            end
        end
    end

    // phase is held at 0 whenever autofire is idle, so this reduces to ~stable.
    assign jp_ab = ~stable[1:0] | phase;
`else
    assign jp_ab = ~stable[1:0];
`endif

    assign bus.joypad_a      = jp_ab[0];
    assign bus.joypad_b      = jp_ab[1];
    assign bus.joypad_select = ~stable[2];
    assign bus.joypad_start  = ~stable[3];
    assign bus.joypad_right  = ~stable[4];
    assign bus.joypad_left   = ~stable[5];
    assign bus.joypad_up     = ~stable[6];
    assign bus.joypad_down   = ~stable[7];
    assign bus.btn_state     = stable;
    assign bus.joy_irq       = irq;

endmodule

// File: tb/tb_joypad_conditioner.sv
// Directed bench for joypad_conditioner with DEBOUNCE_CYCLES=4, TURBO_PERIOD=3.
// Checks use immediate assertions; define TURBO_EN to exercise autofire.
module tb_joypad_conditioner;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic irq_seen;
    logic [7:0] jp;

    joypad_conditioner_if bus ();

    joypad_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .TURBO_PERIOD(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign jp = {bus.joypad_down, bus.joypad_up,
                 bus.joypad_left, bus.joypad_right,
                 bus.joypad_start, bus.joypad_select,
                 bus.joypad_b, bus.joypad_a};

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] pat;
        n_pass      = 0;
        n_total     = 0;
        rst         = 1'b1;
        bus.btn_raw = 8'hFF;
        bus.turbo_on = 1'b0;

        // 1. reset value with all buttons raw-pressed
        tick(3);
        chk("rst_jp", jp, 8'hFF);
        chk("rst_state", bus.btn_state, 8'h00);
        chk("rst_irq", {7'd0, bus.joy_irq}, 8'h00);

        bus.btn_raw = 8'h00;
        tick(1);
        rst = 1'b0;
        tick(8);
        chk("idle_state", bus.btn_state, 8'h00);

        // 2. clean press of A
        bus.btn_raw = 8'h01;
        tick(5);
        chk("a_p5_state", bus.btn_state, 8'h00);
        chk("a_p5_irq", {7'd0, bus.joy_irq}, 8'h00);
        tick(1);
        chk("a_p6_state", bus.btn_state, 8'h01);
        chk("a_p6_jp", jp, 8'hFE);
        chk("a_p6_irq", {7'd0, bus.joy_irq}, 8'h01);
        tick(1);
        chk("a_p7_irq", {7'd0, bus.joy_irq}, 8'h00);

        // 3. glitch on up for 3 cycles while A held
        irq_seen = 1'b0;
        bus.btn_raw = 8'h41;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            irq_seen |= bus.joy_irq;
        end
        bus.btn_raw = 8'h01;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            irq_seen |= bus.joy_irq;
        end
        chk("glitch_up", {7'd0, bus.joypad_up}, 8'h01);
        chk("glitch_state", bus.btn_state, 8'h01);
        chk("glitch_irq", {7'd0, irq_seen}, 8'h00);

        // 4. simultaneous select+start (A released)
        bus.btn_raw = 8'h0C;
        tick(5);
        chk("sim_p5_state", bus.btn_state, 8'h01);
        tick(1);
        chk("sim_p6_state", bus.btn_state, 8'h0C);
        chk("sim_p6_jp", jp, 8'hF3);
        chk("sim_p6_irq", {7'd0, bus.joy_irq}, 8'h01);
        tick(1);
        chk("sim_p7_irq", {7'd0, bus.joy_irq}, 8'h00);

        irq_seen = 1'b0;
        bus.btn_raw = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            irq_seen |= bus.joy_irq;
        end
        chk("rel_p5_state", bus.btn_state, 8'h0C);
        tick(1);
        irq_seen |= bus.joy_irq;
        chk("rel_p6_state", bus.btn_state, 8'h00);
        tick(2);
        irq_seen |= bus.joy_irq;
        chk("rel_irq", {7'd0, irq_seen}, 8'h00);

        // 5. reset in the middle of debouncing down
        bus.btn_raw = 8'h10;
        tick(6);
        chk("right_state", bus.btn_state, 8'h10);
        tick(2);
        bus.btn_raw = 8'h90;
        tick(4);
        rst = 1'b1;
        #1;
        chk("mid_rst_state", bus.btn_state, 8'h00);
        chk("mid_rst_jp", jp, 8'hFF);
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("re_p5_state", bus.btn_state, 8'h00);
        tick(1);
        chk("re_p6_state", bus.btn_state, 8'h90);
        chk("re_p6_irq", {7'd0, bus.joy_irq}, 8'h01);

        // 6. autofire on A
        bus.turbo_on = 1'b1;
        bus.btn_raw  = 8'h01;
        tick(5);
        chk("t_p5_state", bus.btn_state, 8'h90);
`ifdef TURBO_EN
        pat = 7'b0111000;
`else
        pat = 7'b0000000;
`endif
        for (int i = 0; i < 7; i++) begin
            tick(1);
            chk($sformatf("t_a_%0d", i),
                {7'd0, bus.joypad_a}, {7'd0, pat[i]});
            chk($sformatf("t_st_%0d", i),
                bus.btn_state, 8'h01);
        end
        bus.turbo_on = 1'b0;
        tick(2);
        chk("t_off_a", {7'd0, bus.joypad_a}, 8'h00);
        bus.btn_raw = 8'h00;
        tick(6);
        chk("t_rel_a", {7'd0, bus.joypad_a}, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed hang expected finish");
        $fatal(1);
    end

endmodule
